// File: rtl/fe_branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// fe_branch_predictor_pkg : shared BTB sizing, AGEX->FE bundle widths, helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fe_branch_predictor_pkg;

  localparam int BTB_IDX_BITS = 4;

  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam logic [1:0] CTR_MAX   = 2'd3;
  localparam logic [1:0] CTR_MIN   = 2'd0;

  // Bundle field order: res_valid, res_pc, res_is_branch, res_taken,
  // res_target, res_pred_taken, res_pred_target.
  function automatic int from_agex_to_fe_width(input int dbits);
    return 1 + dbits + 1 + 1 + dbits + 1 + dbits;
  endfunction

  // Width of the {pred_taken, pred_target} pair riding in the FE/DE/AGEX latches.
  function automatic int pred_pair_width(input int dbits);
    return 1 + dbits;
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_MAX) nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_MIN) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fe_branch_predictor_bp_btb_table.sv
// ---------------------------------------------------------------------------
// bp_btb_table : direct-mapped BTB storage, 1 comb read port, 1 training port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_btb_table
  import fe_branch_predictor_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int IDX_BITS = BTB_IDX_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IDX_BITS-1:0]         rd_idx_i,
  input  logic [DBITS-IDX_BITS-3:0]   rd_tag_i,
  output logic                        rd_hit_o,
  output logic [1:0]                  rd_ctr_o,
  output logic [DBITS-1:0]            rd_target_o,
  input  logic                        wr_en_i,
  input  logic [IDX_BITS-1:0]         wr_idx_i,
  input  logic [DBITS-IDX_BITS-3:0]   wr_tag_i,
  input  logic                        wr_is_branch_i,
  input  logic                        wr_taken_i,
  input  logic [DBITS-1:0]            wr_target_i
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = DBITS - IDX_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [DBITS-1:0] target_q [ENTRIES];

  logic       wr_hit;
  logic       state_we;
  logic       data_we;
  logic       valid_d;
  logic [1:0] ctr_d;

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

  assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

  always_comb begin
    state_we = 1'b0;
    data_we  = 1'b0;
    valid_d  = valid_q[wr_idx_i];
    ctr_d    = ctr_q[wr_idx_i];
    if (wr_en_i) begin
      if (wr_is_branch_i) begin
        if (wr_hit) begin
          state_we = 1'b1;
          ctr_d    = ctr_update(ctr_q[wr_idx_i], wr_taken_i);
          data_we  = wr_taken_i;
        end else if (wr_taken_i) begin
          state_we = 1'b1;
          valid_d  = 1'b1;
          ctr_d    = CTR_ALLOC;
          data_we  = 1'b1;
        end
      end else if (wr_hit) begin
        // A non-branch matched the tag: the entry is an alias, drop it.
        state_we = 1'b1;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_MIN;
      end
    end else if (state_we) begin
      valid_q[wr_idx_i] <= valid_d;
      ctr_q[wr_idx_i]   <= ctr_d;
    end
  end

  // Tag/target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (data_we) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fe_branch_predictor.sv
// ---------------------------------------------------------------------------
// fe_branch_predictor : BTB lookup, mispredict redirect/flush, branch stats
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fe_branch_predictor
  import fe_branch_predictor_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int IDX_BITS = BTB_IDX_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fe_valid,
  input  logic [DBITS-1:0] fe_pc,
  output logic             pred_taken,
  output logic [DBITS-1:0] pred_target,
  input  logic             res_valid,
  input  logic [DBITS-1:0] res_pc,
  input  logic             res_is_branch,
  input  logic             res_taken,
  input  logic [DBITS-1:0] res_target,
  input  logic             res_pred_taken,
  input  logic [DBITS-1:0] res_pred_target,
  output logic             redirect_valid,
  output logic [DBITS-1:0] redirect_pc,
  output logic             flush,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);

  localparam int TAG_W = DBITS - IDX_BITS - 2;

  logic             lk_hit;
  logic [1:0]       lk_ctr;
  logic [DBITS-1:0] lk_target;

  logic             mispredict;
  logic [DBITS-1:0] redirect_pc_d;
  logic             redirect_valid_q;
  logic [DBITS-1:0] redirect_pc_q;
  logic [31:0]      br_count_q;
  logic [31:0]      mispred_count_q;

  bp_btb_table #(
    .DBITS    (DBITS),
    .IDX_BITS (IDX_BITS)
  ) u_btb (
    .clk            (clk),
    .reset          (reset),
    .rd_idx_i       (fe_pc[IDX_BITS+1:2]),
    .rd_tag_i       (fe_pc[DBITS-1:IDX_BITS+2]),
    .rd_hit_o       (lk_hit),
    .rd_ctr_o       (lk_ctr),
    .rd_target_o    (lk_target),
    .wr_en_i        (res_valid),
    .wr_idx_i       (res_pc[IDX_BITS+1:2]),
    .wr_tag_i       (res_pc[DBITS-1:IDX_BITS+2]),
    .wr_is_branch_i (res_is_branch),
    .wr_taken_i     (res_taken),
    .wr_target_i    (res_target)
  );

  assign pred_taken  = fe_valid & lk_hit & lk_ctr[1];
  assign pred_target = pred_taken ? lk_target : fe_pc + DBITS'(4);

  // A correct not-taken prediction matches regardless of the carried target.
  assign mispredict = res_valid &
                      ((res_taken != res_pred_taken) |
                       (res_taken & (res_target != res_pred_target)));
  assign redirect_pc_d = res_taken ? res_target : res_pc + DBITS'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      mispred_count_q  <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_pc_d;
      if (res_valid && res_is_branch) br_count_q <= br_count_q + 32'd1;
      if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = redirect_valid_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

  if (TAG_W < 1) begin : g_bad_params
    $error("DBITS too small for IDX_BITS");
  end

endmodule

`default_nettype wire

// File: doc/fe_branch_predictor.md
# fe_branch_predictor

Fetch-side branch predictor and redirect unit, the receiving end of the AGEX-to-FE path. It gives FE a same-cycle next-PC prediction from a direct-mapped BTB with 2-bit counters. It takes branch/jump resolutions from AGEX, trains its tables on them, and on a misprediction issues a registered one-cycle redirect and flush to FE and DE. It also keeps branch and mispredict statistics counters.

## Interface
Parameters:
- DBITS, 32, data/PC width
- IDX_BITS, 4, BTB index width (2^IDX_BITS entries)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- fe_valid  in  1  FE is presenting a PC this cycle
- fe_pc  in  DBITS  current fetch PC (word aligned)
- pred_taken  out  1  prediction for fe_pc
- pred_target  out  DBITS  predicted next PC
- res_valid  in  1  AGEX resolution valid this cycle
- res_pc  in  DBITS  PC of the resolved instruction
- res_is_branch  in  1  instruction is BEQ..BGEU/JAL/JALR
- res_taken  in  1  actual direction (br_cond, or 1 for jumps)
- res_target  in  DBITS  actual taken target
- res_pred_taken  in  1  prediction carried down the pipe with the instruction
- res_pred_target  in  DBITS  predicted target carried down the pipe
- redirect_valid  out  1  registered mispredict pulse
- redirect_pc  out  DBITS  correct next PC
- flush  out  1  equals redirect_valid; squashes the FE and DE latches
- br_count  out  32  resolved branches with res_is_branch=1
- mispred_count  out  32  mispredicts

## Operation
- Index = pc[IDX_BITS+1:2]. Tag = pc[DBITS-1:IDX_BITS+2]. Each entry holds valid, tag, target[DBITS], and a 2-bit counter ctr.
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = fe_valid & hit & ctr[1].
  - pred_target = pred_taken ? target : fe_pc+4.
- Mispredict is res_valid & (res_taken != res_pred_taken | (res_taken & res_target != res_pred_target)).
  - redirect_pc = res_taken ? res_target : res_pc+4. All additions wrap mod 2^DBITS.
- Training, at the posedge after res_valid:
  - Branch with a hit: ctr saturates up on taken (max 3) and down on not-taken (min 0). On taken, target is overwritten with res_target.
  - Branch that misses and was taken: allocate the entry with valid=1, tag, target, ctr=2.
  - Branch that misses and was not taken: no change.
  - res_is_branch=0 with a hit (alias): clear valid. The mispredict rule covers the case res_pred_taken=1.
- Counters:
  - br_count increments on res_valid & res_is_branch.
  - mispred_count increments on every mispredict.
  - Both wrap at 2^32.

## Timing
- Prediction latency is 0 cycles; pred_* depends only on fe_pc and state.
- Redirect latency is 1 cycle. redirect_valid, redirect_pc and flush are registered and asserted for exactly the one cycle after the resolving cycle.
  - Back-to-back mispredicts give back-to-back pulses, each carrying its own PC.
- Table writes take effect at the clock edge. A lookup to the same index in the same cycle as an update sees the pre-update contents; there is no bypass.
- Reset (any time, including mid-redirect) clears:
  - all valid bits and all counters;
  - redirect_valid=0, redirect_pc=0, flush=0.
  - Reset drops any pending redirect. Target and tag contents may retain stale values because valid gates them.
- After reset deasserts, pred_taken=0 until the first training.

## Structure
- Shared header VX_define.vh holds:
  - BTB_IDX_BITS;
  - from_AGEX_to_FE_WIDTH and the field order of the resolution bundle (res_valid, res_pc, res_is_branch, res_taken, res_target, res_pred_taken, res_pred_target);
  - the width of the pred_* pair carried in the FE/DE/AGEX latches.
- One sub-module, bp_btb_table: the entry storage with one combinational read port, one synchronous write port, and an async-reset valid/ctr array.
- Top level holds mispredict detection, the redirect register and the statistics counters.

## Test plan
- Reset then lookup pc=0x100 → pred_taken=0, pred_target=0x104. All outputs 0, counters 0.
- Resolve a taken branch at pc=0x100 → 0x200 (res_pred_taken=0):
  - next cycle: redirect_valid=1 and redirect_pc=0x200 for one cycle; mispred_count=1; br_count=1.
  - a subsequent lookup of 0x100 predicts taken to 0x200 (ctr=2).
- Three not-taken resolutions of 0x100 after allocation:
  - ctr goes 2→1→0→0 (saturates);
  - the first gives redirect_pc=0x104;
  - lookup predicts not-taken after the first.
- Aliasing: 0x100 trained taken, then 0x1100 (same index, different tag) looks up → miss. A non-branch resolution at 0x100 with res_pred_taken=1 → redirect to 0x104 and the entry is invalidated.
- Same-cycle lookup and update of index 0 → the old prediction is returned; the new one appears the next cycle.
- Assert reset during a redirect cycle → redirect_valid drops immediately and the table is cleared. Also drive 2^32 mispredicts (or force the counter) → mispred_count wraps to 0.
